// File: rtl/divider_monitor.sv
// divider_monitor
//   Measures the half-period of a divided clock (divided_in) in pulse_clock
//   cycles, reports each measurement with a one-cycle strobe, declares lock
//   after LOCK_COUNT consecutive equal measurements and flags a sticky
//   timeout when divided_in stops toggling.
//
// Ports
//   pulse_clock    : sole clock, rising edge
//   external_reset : synchronous, active-high reset
//   enable         : 1 = monitor active, 0 = return to IDLE
//   divided_in     : clock under test, asynchronous to pulse_clock
//   measured_half  : most recent half-period in pulse_clock cycles
//   ratio_valid    : one-cycle strobe, measured_half updated this cycle
//   locked         : high while LOCK_COUNT consecutive equal measurements hold
//   timeout_err    : sticky, no divided_in edge within TIMEOUT cycles
module divider_monitor #(
   parameter int unsigned LOCK_COUNT = 4,
   parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
   input  logic        pulse_clock,
   input  logic        external_reset,
   input  logic        enable,
   input  logic        divided_in,
   output logic [31:0] measured_half,
   output logic        ratio_valid,
   output logic        locked,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

   localparam logic [3:0] MATCH_MAX = 4'(LOCK_COUNT - 1);

   state_t      state, state_nxt;
   logic        sync1, sync2, sync3;
   logic        det_edge;
   logic [31:0] counter, counter_nxt;
   logic [31:0] half_nxt;
   logic [3:0]  match_cnt, match_nxt;
   logic        rv_nxt, err_nxt;

   // sync1/sync2 resolve metastability; sync3 remembers the previous
   // synchronized level so both polarities of transition are seen.
   assign det_edge = sync2 ^ sync3;
   assign locked   = (state == LOCKED);

   always_ff @(posedge pulse_clock) begin
      if (external_reset) begin
         state         <= IDLE;
         sync1         <= 1'b0;
         sync2         <= 1'b0;
         sync3         <= 1'b0;
         counter       <= '0;
         match_cnt     <= '0;
         measured_half <= '0;
         ratio_valid   <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_nxt;
         sync1         <= divided_in;
         sync2         <= sync1;
         sync3         <= sync2;
         counter       <= counter_nxt;
         match_cnt     <= match_nxt;
         measured_half <= half_nxt;
         ratio_valid   <= rv_nxt;
         timeout_err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      half_nxt    = measured_half;
      match_nxt   = match_cnt;
      rv_nxt      = 1'b0;
      err_nxt     = timeout_err;

      if (!enable) begin
         state_nxt   = IDLE;
         counter_nxt = '0;
         match_nxt   = '0;
         err_nxt     = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt   = ARM;
               counter_nxt = '0;
               match_nxt   = '0;
            end
            ARM: begin
               // First edge only establishes a reference point.
               if (det_edge) begin
                  counter_nxt = 32'd1;
                  state_nxt   = MEASURE;
               end else if (counter == TIMEOUT) begin
                  err_nxt     = 1'b1;
                  counter_nxt = '0;
               end else begin
                  counter_nxt = counter + 32'd1;
               end
            end
            MEASURE, LOCKED: begin
               // An edge wins over a simultaneous timeout.
               if (det_edge) begin
                  half_nxt    = counter;
                  rv_nxt      = 1'b1;
                  counter_nxt = 32'd1;
                  if (counter == measured_half)
                     match_nxt = (match_cnt >= MATCH_MAX) ? MATCH_MAX : match_cnt + 4'd1;
                  else
                     match_nxt = '0;
                  state_nxt = (match_nxt == MATCH_MAX) ? LOCKED : MEASURE;
               end else if (counter == TIMEOUT) begin
                  err_nxt     = 1'b1;
                  match_nxt   = '0;
                  counter_nxt = '0;
                  state_nxt   = ARM;
               end else begin
                  counter_nxt = (counter == 32'hFFFF_FFFF) ? counter : counter + 32'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_monitor.sv
// Bench for divider_monitor: directed scenarios followed by randomized
// half-periods, enable drops and reset pulses. A behavioural model tracks
// time since the last reload and the run of equal measurements; every cycle
// all four outputs are compared against it.
module tb_divider_monitor;

   localparam int LC = 4;
   localparam int TO = 50;

   logic        pulse_clock = 1'b0;
   logic        external_reset;
   logic        enable;
   logic        divided_in;
   logic [31:0] measured_half;
   logic        ratio_valid;
   logic        locked;
   logic        timeout_err;

   divider_monitor #(.LOCK_COUNT(LC), .TIMEOUT(32'(TO))) dut (
      .pulse_clock    (pulse_clock),
      .external_reset (external_reset),
      .enable         (enable),
      .divided_in     (divided_in),
      .measured_half  (measured_half),
      .ratio_valid    (ratio_valid),
      .locked         (locked),
      .timeout_err    (timeout_err)
   );

   always #5 pulse_clock = ~pulse_clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model. mode: 0 idle, 1 waiting for first edge, 2 measuring.
   // m_since counts cycles since the last reload; m_streak is the number of
   // captures in a row that repeated the previous measurement.
   int          m_mode = 0;
   logic [31:0] m_since = 0;
   logic [31:0] m_meas = 0;
   int          m_streak = 0;
   bit          m_rv = 0, m_err = 0, m_locked = 0;
   bit          hist[$] = '{0, 0, 0};  // samples of divided_in, oldest first

   task automatic model_step();
      bit e;
      if (external_reset) begin
         m_mode = 0; m_since = 0; m_meas = 0; m_streak = 0;
         m_rv = 0; m_err = 0;
         hist = '{0, 0, 0};
      end else begin
         // A level change becomes visible three samples after it is taken.
         e = (hist[1] != hist[0]);
         hist.push_back(divided_in);
         void'(hist.pop_front());
         m_rv = 0;
         if (!enable) begin
            m_mode = 0; m_since = 0; m_streak = 0; m_err = 0;
         end else if (m_mode == 0) begin
            m_mode = 1; m_since = 0; m_streak = 0;
         end else if (e) begin
            if (m_mode == 2) begin
               m_rv = 1;
               if (m_since == m_meas) m_streak++;
               else m_streak = 0;
               m_meas = m_since;
            end
            m_mode = 2;
            m_since = 1;
         end else if (m_since == TO) begin
            m_err = 1; m_since = 0; m_streak = 0; m_mode = 1;
         end else if (m_since != 32'hFFFF_FFFF) begin
            m_since++;
         end
      end
      m_locked = (m_mode == 2) && (m_streak >= LC - 1);
   endtask

   task automatic cycle();
      @(posedge pulse_clock);
      model_step();
      @(negedge pulse_clock);
      chk("measured_half", measured_half, m_meas);
      chk("ratio_valid", 32'(ratio_valid), 32'(m_rv));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
   endtask

   task automatic run_half(input int n);
      divided_in = ~divided_in;
      repeat (n) cycle();
   endtask

   int last_len = 10;

   initial begin
      external_reset = 1'b1;
      enable         = 1'b0;
      divided_in     = 1'b0;
      cycle();
      cycle();
      chk("rst_half", measured_half, 0);
      chk("rst_rv", 32'(ratio_valid), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_err", 32'(timeout_err), 0);
      external_reset = 1'b0;

      // Steady 10-cycle half-periods reach lock.
      enable = 1'b1;
      repeat (3) cycle();
      repeat (8) run_half(10);
      chk("lock10_half", measured_half, 10);
      chk("lock10_locked", 32'(locked), 1);

      // One stretched half-period breaks lock; four more equal ones relock.
      run_half(13);
      repeat (6) run_half(10);
      chk("relock_locked", 32'(locked), 1);

      // Input stalls: timeout after TO cycles.
      repeat (60) cycle();
      chk("timeout_err", 32'(timeout_err), 1);
      chk("timeout_locked", 32'(locked), 0);

      // Enable low clears the error but keeps the last measurement.
      enable = 1'b0;
      repeat (2) cycle();
      chk("dis_err", 32'(timeout_err), 0);
      chk("dis_half", measured_half, 10);

      // Edge exactly at the timeout boundary is a capture.
      enable = 1'b1;
      repeat (2) cycle();
      repeat (3) run_half(TO);
      chk("edge_at_to_half", measured_half, 32'(TO));
      chk("edge_at_to_err", 32'(timeout_err), 0);

      // Reset while locked.
      repeat (6) run_half(7);
      chk("pre_rst_locked", 32'(locked), 1);
      external_reset = 1'b1;
      cycle();
      external_reset = 1'b0;
      chk("midlock_rst_half", measured_half, 0);
      chk("midlock_rst_locked", 32'(locked), 0);
      chk("midlock_rst_rv", 32'(ratio_valid), 0);

      // Enable dropped part way through a measurement.
      repeat (4) run_half(7);
      divided_in = ~divided_in;
      repeat (3) cycle();
      enable = 1'b0;
      repeat (3) cycle();
      chk("drop_half", measured_half, 7);
      chk("drop_err", 32'(timeout_err), 0);
      chk("drop_locked", 32'(locked), 0);
      enable = 1'b1;

      // Randomized traffic: mostly repeated half-periods so lock is reached,
      // occasional long gaps for timeouts, enable drops and reset pulses.
      repeat (300) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            external_reset = 1'b1;
            cycle();
            external_reset = 1'b0;
         end else if (r < 7) begin
            enable = ~enable;
         end
         if ($urandom_range(0, 9) < 3) last_len = int'($urandom_range(1, 60));
         run_half(last_len);
      end

      // Constant input: no strobes at all.
      enable = 1'b1;
      repeat (2 * TO) begin
         cycle();
         chk("const_rv", 32'(ratio_valid), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/divider_monitor.md
DIVIDER_MONITOR -- requirements
Module: divider_monitor

Interface
REQ-001 Parameter LOCK_COUNT, default 4: number of consecutive equal half-period measurements required to assert locked (legal range 2..15).
REQ-002 Parameter TIMEOUT, default 32'd1000000: pulse_clock cycles without a divided_in edge before timeout_err is raised.
REQ-003 pulse_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 external_reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high = monitor active; low = return to IDLE.
REQ-006 divided_in  input  1  divided clock under test, asynchronous to pulse_clock.
REQ-007 measured_half  output  32  most recent half-period, in pulse_clock cycles.
REQ-008 ratio_valid  output  1  one-cycle strobe; measured_half updated this cycle.
REQ-009 locked  output  1  high while LOCK_COUNT consecutive equal measurements hold.
REQ-010 timeout_err  output  1  sticky; no divided_in edge seen within TIMEOUT cycles.

Function
REQ-011 divided_in SHALL pass through a 2-flop synchronizer; a third flop SHALL hold the previous synchronized value; edge = XOR of the last two, so both rising and falling edges are detected.
REQ-012 Detected edge SHALL occur on the 3rd pulse_clock rising edge after the first edge that samples divided_in at its new level.
REQ-013 States SHALL be IDLE, ARM, MEASURE and LOCKED.
REQ-014 IDLE: counter = 0, match count = 0; enable high -> ARM next cycle.
REQ-015 ARM: first detected edge loads counter = 1 and moves to MEASURE, with no capture and no ratio_valid.
REQ-016 MEASURE/LOCKED, edge cycle: measured_half <= counter; ratio_valid = 1 for exactly that cycle; counter <= 1.
REQ-017 MEASURE/LOCKED, non-edge cycle: counter SHALL increment by 1, saturating at 32'hFFFFFFFF.
REQ-018 Match count: on capture, if new value equals previous measured_half, increment (saturating at LOCK_COUNT-1); otherwise clear to 0.
REQ-019 Lock entry: MEASURE -> LOCKED on the capture where match count reaches LOCK_COUNT-1; locked SHALL go high the same cycle as that ratio_valid.
REQ-020 Lock loss: in LOCKED, a mismatching capture SHALL return to MEASURE and clear locked and match count in the same cycle.
REQ-021 Timeout: in ARM, MEASURE or LOCKED, counter == TIMEOUT with no edge SHALL set timeout_err = 1, clear locked and match count, and move to ARM.
REQ-022 Simultaneous edge and timeout: the edge SHALL take priority and timeout is not raised.
REQ-023 enable low in any state: IDLE next cycle; locked = 0, ratio_valid = 0, timeout_err cleared; measured_half holds its value.
REQ-024 Constant divided_in: no ratio_valid SHALL ever be issued.

Reset
REQ-025 external_reset high at a rising edge SHALL force: state IDLE; synchronizer flops 0; counter 0; match count 0; measured_half 0; ratio_valid 0; locked 0; timeout_err 0.
REQ-026 Reset SHALL override enable and any in-progress measurement, including mid-lock.

Verification
REQ-027 enable=1; divided_in toggles every 10 cycles -> ratio_valid strobes every 10 cycles; measured_half = 10; locked high at the 4th capture.
REQ-028 Locked at 10; one half-period stretched to 13 -> measured_half = 13; locked drops the same cycle; relock after 4 further captures of 10.
REQ-029 TIMEOUT=50; divided_in held low after lock -> timeout_err = 1 and locked = 0 exactly 50 cycles after the last counter reload; state ARM.
REQ-030 Edge arriving on the cycle counter == TIMEOUT -> capture = TIMEOUT; timeout_err stays 0.
REQ-031 external_reset pulsed while locked -> all outputs 0 the next cycle; after enable, first edge produces no ratio_valid (ARM).
REQ-032 enable dropped mid-MEASURE -> IDLE; timeout_err = 0; measured_half retains its last value.
